// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// The queue itself uses the slave modport; fetch/decode drive through master.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic          in_valid;
    logic [31:0]   in_pc4;
    logic [31:0]   in_ins;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc4;
    logic [31:0]   out_ins;
    logic [CW-1:0] count;

    modport master (
        output flush, in_valid, in_pc4, in_ins, out_ready,
        input  in_ready, out_valid, out_pc4, out_ins, count
    );

    modport slave (
        input  flush, in_valid, in_pc4, in_ins, out_ready,
        output in_ready, out_valid, out_pc4, out_ins, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue with taken-branch flush.
// Define FETCH_QUEUE_NOP_EN to present a NOP (all zeros) on the outputs whenever the queue is empty.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_r;
    logic          push;
    logic          pop;

    // Handshake flags come from the registered count only, so out_ready never reaches in_ready.
    assign q.in_ready  = (count_r != CW'(DEPTH));
    assign q.out_valid = (count_r != '0);
    assign q.count     = count_r;

    assign push = q.in_valid && q.in_ready && !q.flush;
    assign pop  = q.out_valid && q.out_ready && !q.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else if (q.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count_r <= count_r + CW'(1);
            else if (pop && !push)
                count_r <= count_r - CW'(1);
        end
    end

    // Storage is data only: never reset, and a flush leaves stale entries in place.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {q.in_pc4, q.in_ins};
    end

`ifdef FETCH_QUEUE_NOP_EN
    assign q.out_pc4 = q.out_valid ? mem[rd_ptr][63:32] : 32'h0000_0000;
    assign q.out_ins = q.out_valid ? mem[rd_ptr][31:0]  : 32'h0000_0000;
`else
    assign q.out_pc4 = mem[rd_ptr][63:32];
    assign q.out_ins = mem[rd_ptr][31:0];
`endif
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction decoupling queue between the fetch stage and the decode stage. Each entry is a fetched instruction word with its PC+4. Fetch pushes one entry per cycle while space remains, and decode pops one per cycle when ready. The queue absorbs decode stalls without back-pressuring the program counter combinationally, and a flush from taken-branch resolution discards all queued wrong-path instructions.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- CW, $clog2(DEPTH)+1, width of occupancy count (derived, not overridden)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears queue
- flush  input  1  synchronous discard of all entries (taken branch, PCSrc=1)
- in_valid  input  1  fetch presents an entry
- in_pc4  input  32  PC+4 of the fetched instruction
- in_ins  input  32  fetched instruction word
- in_ready  output  1  queue accepts an entry this cycle
- out_valid  output  1  head entry available
- out_ready  input  1  decode consumes head this cycle
- out_pc4  output  32  PC+4 of head entry
- out_ins  output  32  head instruction word
- count  output  CW  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH×64-bit array; write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits; register count holds occupancy.
- in_ready = (count != DEPTH). A push while full is refused, even if a pop happens in the same cycle.
- out_valid = (count != 0). out_pc4/out_ins = array[rd_ptr].
- Push: in_valid && in_ready && !flush → write {in_pc4,in_ins} at wr_ptr; wr_ptr+1.
- Pop: out_valid && out_ready && !flush → rd_ptr+1.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Pointer wrap: modulo DEPTH by natural overflow, so DEPTH−1 → 0.
- Flush has priority. wr_ptr, rd_ptr and count go to 0 next cycle. A same-cycle push or pop is ignored. Array contents are left unchanged.
- in_valid with in_ready=0: no state change. Fetch must hold its entry.
- out_ready with out_valid=0: no state change.
- Array contents are not reset. Only pointers and count are reset.

## Timing
- Reset (async assert, any time including mid-operation): count=0, wr_ptr=rd_ptr=0, in_ready=1, out_valid=0. out_pc4/out_ins hold whatever array[0] contains (0 under FETCH_QUEUE_NOP_EN).
- Push-to-output latency is 1 cycle. An entry pushed at edge N is visible on out_* after edge N, with no same-cycle bypass into an empty queue.
- Throughput is 1 push and 1 pop per cycle in steady state, with 1 ≤ count < DEPTH.
- in_ready and out_valid are functions of registered count only, so there is no combinational path from out_ready to in_ready.
- Flush at edge N: out_valid=0 and in_ready=1 after edge N. The first post-flush push can occur at edge N+1.
- Reset deassertion: the first push is accepted at the first rising edge after deassertion.

## Configuration
- FETCH_QUEUE_NOP_EN defined: out_ins is forced to 32'h0000_0000 (MIPS sll $0,$0,0, a NOP) and out_pc4 to 0 whenever out_valid=0. Decode can then consume a bubble without gating on valid. This also covers the reset and post-flush states.
- Undefined: out_ins/out_pc4 show array[rd_ptr] regardless of out_valid, and the values are meaningless when out_valid=0.

## Test plan
DEPTH=4 throughout.
- Reset then idle: assert reset mid-cycle → count=0, in_ready=1, out_valid=0 immediately. With NOP_EN, out_ins=0.
- Fill: push ins 0x8C010000, 0x8C020004, 0x00221820, 0xAC030008 (pc4 4,8,12,16) with out_ready=0 → count=4, in_ready=0, out_ins=0x8C010000. A fifth push is refused and count stays 4.
- Drain with wrap: from full, pop 4 while pushing 0x20040001 on the 1st pop cycle (refused, full) and on the 2nd (accepted) → pops return entries 1–4 in order. count sequence is 3,3,2,1, then a 5th pop returns 0x20040001 via wrapped rd_ptr.
- Simultaneous push/pop at count=2 for 10 cycles → count stays 2 and output order matches input order.
- Flush with concurrent push and pop at count=3 → next cycle count=0 and out_valid=0. The pushed entry never appears. A push on the following edge appears at out_ins.
- Async reset asserted while count=2 and a push is pending → count=0 without a clock edge. After release, the first push returns that entry with a 1-cycle latency.
